// File: rtl/sti_pack_engine.sv
// Parallel-to-serial frame packer: a captured word becomes a 1..MAX_BYTES byte frame that is
// shifted out one bit per cycle, with each completed byte written to a pixel memory port.
module sti_pack_engine #(
    parameter int         DATA_W    = 16,
    parameter int         MAX_BYTES = 4,
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] PAD_VALUE = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] pi_data,
    input  logic [1:0]        pi_length,
    input  logic              pi_fill,
    input  logic              pi_msb,
    input  logic              pi_low,
    input  logic              pi_end,
    output logic              ready,
    output logic              so_data,
    output logic              so_valid,
    output logic              pixel_wr,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [7:0]        pixel_dataout,
    output logic              pixel_finish,
    output logic              ovf
);

    localparam int                FRAME_W    = 8 * MAX_BYTES;
    localparam logic [5:0]        DATA_BITS  = 6'(DATA_W);
    localparam logic [5:0]        FRAME_BITS = 6'(FRAME_W);
    localparam logic [2:0]        MAX_N      = 3'(MAX_BYTES);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        SHIFT,
        FILL,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [2:0]          bytes_q, bytes_d;
    logic                fill_q, fill_d;
    logic                msb_q, msb_d;
    logic                low_q, low_d;
    logic                end_q, end_d;
    logic [FRAME_W-1:0]  sreg_q, sreg_d;
    logic [6:0]          byte_q, byte_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic                ready_q, ready_d;
    logic                so_data_q, so_data_d;
    logic                so_valid_q, so_valid_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          dout_q, dout_d;
    logic                finish_q, finish_d;
    logic                ovf_q, ovf_d;
    logic                wrote_q, wrote_d;

    logic [2:0]          req_n;
    logic [5:0]          frame_bits;
    logic [FRAME_W-1:0]  data_ext;
    logic [FRAME_W-1:0]  frame_v;
    logic [FRAME_W-1:0]  sreg_init;
    logic [FRAME_W-1:0]  sreg_src;
    logic                tx_bit;
    logic [7:0]          tx_byte;

    // Frame construction from the captured word and mode bits.
    always_comb begin
        req_n      = {1'b0, pi_length} + 3'd1;
        frame_bits = {bytes_q, 3'b000};
        data_ext   = FRAME_W'(data_q);
        if (frame_bits > DATA_BITS) begin
            frame_v = fill_q ? data_ext << (frame_bits - DATA_BITS) : data_ext;
        end else if (frame_bits < DATA_BITS) begin
            frame_v = low_q ? data_ext >> (DATA_BITS - frame_bits)
                            : data_ext & ({FRAME_W{1'b1}} >> (FRAME_BITS - frame_bits));
        end else begin
            frame_v = data_ext;
        end
        // MSB-first frames are left-aligned so each order always shifts out of one fixed end.
        sreg_init = msb_q ? frame_v << (FRAME_BITS - frame_bits) : frame_v;
    end

    always_comb begin
        // NOTE: every variable gets a default here so no path through the case infers a latch.
        state_d    = state_q;
        data_d     = data_q;
        bytes_d    = bytes_q;
        fill_d     = fill_q;
        msb_d      = msb_q;
        low_d      = low_q;
        end_d      = end_q;
        sreg_d     = sreg_q;
        byte_d     = byte_q;
        bit_cnt_d  = bit_cnt_q;
        addr_d     = addr_q;
        ovf_d      = ovf_q;
        wrote_d    = wrote_q;
        so_data_d  = 1'b0;
        so_valid_d = 1'b0;
        wr_d       = 1'b0;
        dout_d     = 8'h00;
        finish_d   = 1'b0;

        sreg_src = (state_q == PREP) ? sreg_init : sreg_q;
        tx_bit   = msb_q ? sreg_src[FRAME_W-1] : sreg_src[0];
        tx_byte  = {byte_q, tx_bit};

        case (state_q)
            IDLE: begin
                if (load) begin
                    data_d    = pi_data;
                    bytes_d   = (req_n > MAX_N) ? MAX_N : req_n;
                    fill_d    = pi_fill;
                    msb_d     = pi_msb;
                    low_d     = pi_low;
                    end_d     = pi_end;
                    bit_cnt_d = '0;
                    state_d   = PREP;
                end
            end
            PREP, SHIFT: begin
                if (state_q == SHIFT && bit_cnt_q == frame_bits) begin
                    state_d = end_q ? FILL : IDLE;
                end else begin
                    state_d    = SHIFT;
                    so_valid_d = 1'b1;
                    so_data_d  = tx_bit;
                    sreg_d     = msb_q ? sreg_src << 1 : sreg_src >> 1;
                    byte_d     = tx_byte[6:0];
                    bit_cnt_d  = bit_cnt_q + 6'd1;
                    if (bit_cnt_q[2:0] == 3'd7) begin
                        wr_d    = 1'b1;
                        dout_d  = tx_byte;
                        addr_d  = addr_q + ADDR_ONE;
                        wrote_d = 1'b1;
                        // The reset value of all-ones is a "nothing written yet" marker, not a wrap.
                        if (wrote_q && addr_q == ADDR_LAST) begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            FILL: begin
                if (addr_q == ADDR_LAST) begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                end else begin
                    wr_d   = 1'b1;
                    dout_d = PAD_VALUE;
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            DONE: begin
                finish_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            bytes_q    <= 3'd1;
            fill_q     <= 1'b0;
            msb_q      <= 1'b0;
            low_q      <= 1'b0;
            end_q      <= 1'b0;
            sreg_q     <= '0;
            byte_q     <= '0;
            bit_cnt_q  <= '0;
            ready_q    <= 1'b1;
            so_data_q  <= 1'b0;
            so_valid_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '1;
            dout_q     <= 8'h00;
            finish_q   <= 1'b0;
            ovf_q      <= 1'b0;
            wrote_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bytes_q    <= bytes_d;
            fill_q     <= fill_d;
            msb_q      <= msb_d;
            low_q      <= low_d;
            end_q      <= end_d;
            sreg_q     <= sreg_d;
            byte_q     <= byte_d;
            bit_cnt_q  <= bit_cnt_d;
            ready_q    <= ready_d;
            so_data_q  <= so_data_d;
            so_valid_q <= so_valid_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            finish_q   <= finish_d;
            ovf_q      <= ovf_d;
            wrote_q    <= wrote_d;
        end
    end

    assign ready         = ready_q;
    assign so_data       = so_data_q;
    assign so_valid      = so_valid_q;
    assign pixel_wr      = wr_q;
    assign pixel_addr    = addr_q;
    assign pixel_dataout = dout_q;
    assign pixel_finish  = finish_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_sti_pack_engine.sv
// Bench for sti_pack_engine: a frame-level model predicts every serial bit and memory write,
// a negedge compare process checks the DUT against it, and directed vectors pin literal values.
module tb_sti_pack_engine;

    localparam int         DATA_W    = 16;
    localparam int         MAX_BYTES = 4;
    localparam int         ADDR_W    = 8;
    localparam logic [7:0] PAD       = 8'h5A;

    logic              clk = 1'b0;
    logic              reset;
    logic              load;
    logic [DATA_W-1:0] pi_data;
    logic [1:0]        pi_length;
    logic              pi_fill, pi_msb, pi_low, pi_end;
    logic              ready, so_data, so_valid, pixel_wr, pixel_finish, ovf;
    logic [ADDR_W-1:0] pixel_addr;
    logic [7:0]        pixel_dataout;

    sti_pack_engine #(
        .DATA_W   (DATA_W),
        .MAX_BYTES(MAX_BYTES),
        .ADDR_W   (ADDR_W),
        .PAD_VALUE(PAD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .pi_data      (pi_data),
        .pi_length    (pi_length),
        .pi_fill      (pi_fill),
        .pi_msb       (pi_msb),
        .pi_low       (pi_low),
        .pi_end       (pi_end),
        .ready        (ready),
        .so_data      (so_data),
        .so_valid     (so_valid),
        .pixel_wr     (pixel_wr),
        .pixel_addr   (pixel_addr),
        .pixel_dataout(pixel_dataout),
        .pixel_finish (pixel_finish),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit wrap;
    } wr_exp_t;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_log_t;

    bit      exp_bits[$];
    int      exp_runs[$];
    wr_exp_t exp_wr[$];
    bit      ser_log[$];
    wr_log_t wr_log[$];

    int      n_checks = 0;
    int      n_pass   = 0;
    int      m_addr   = 255;
    int      m_writes = 0;
    bit      chk_en   = 1'b0;
    int      cyc      = 0;
    int      run_len  = 0;
    bit      exp_ovf  = 1'b0;
    wr_exp_t e_cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Model: one frame expressed as its bit sequence and the bytes those bits form.
    function automatic void push_write(input logic [7:0] data);
        wr_exp_t w;
        w.wrap   = (m_addr == 255) && (m_writes > 0);
        m_addr   = (m_addr + 1) % 256;
        m_writes = m_writes + 1;
        w.addr   = m_addr;
        w.data   = int'(data);
        exp_wr.push_back(w);
    endfunction

    function automatic void model_frame(input logic [15:0] d, input logic [1:0] len,
                                        input bit fill, input bit msb, input bit low, input bit endf);
        int          n;
        int          f;
        logic [31:0] v;
        logic [7:0]  acc;
        n = int'(len) + 1;
        if (n > MAX_BYTES) n = MAX_BYTES;
        f = 8 * n;
        if (f > DATA_W)      v = fill ? ({d, 16'h0000} >> (32 - f)) : {16'h0000, d};
        else if (f < DATA_W) v = low ? {24'h0, d[15:8]} : {24'h0, d[7:0]};
        else                 v = {16'h0000, d};
        acc = 8'h00;
        for (int k = 0; k < f; k++) begin
            bit b;
            b = msb ? v[f-1-k] : v[k];
            exp_bits.push_back(b);
            acc = {acc[6:0], b};
            if (k % 8 == 7) push_write(acc);
        end
        exp_runs.push_back(f);
        if (endf) begin
            while (m_addr != 255) begin
                wr_exp_t w;
                m_addr = m_addr + 1;
                w.addr = m_addr;
                w.data = int'(PAD);
                w.wrap = 1'b0;
                exp_wr.push_back(w);
            end
        end
    endfunction

    // Compare process: every cycle, outputs are checked against the model queues.
    always @(negedge clk) begin
        cyc++;
        if (!chk_en) begin
            run_len = 0;
            exp_ovf = 1'b0;
        end else begin
            if (so_valid) begin
                run_len++;
                ser_log.push_back(so_data);
                if (exp_bits.size() == 0) fail_now("so_valid_unexpected");
                else check("so_data", so_data, exp_bits.pop_front());
            end else if (run_len != 0) begin
                if (exp_runs.size() == 0) fail_now("so_run_unexpected");
                else check("so_valid_run_len", run_len, exp_runs.pop_front());
                run_len = 0;
            end
            if (pixel_wr) begin
                wr_log.push_back('{addr: int'(pixel_addr), data: int'(pixel_dataout), cyc: cyc});
                if (exp_wr.size() == 0) fail_now("pixel_wr_unexpected");
                else begin
                    e_cur = exp_wr.pop_front();
                    if (e_cur.wrap) exp_ovf = 1'b1;
                    check("pixel_addr", pixel_addr, e_cur.addr);
                    check("pixel_dataout", pixel_dataout, e_cur.data);
                end
            end else begin
                check("dataout_zero_no_wr", pixel_dataout, 0);
            end
            check("ovf", ovf, exp_ovf);
        end
    end

    function automatic logic [63:0] ser_val(input int start, input int cnt);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < cnt; k++)
            v = {v[62:0], (start + k < ser_log.size()) ? ser_log[start+k] : 1'b0};
        return v;
    endfunction

    task automatic check_wr(input string name, input int idx, input int addr, input int data);
        if (idx >= wr_log.size()) fail_now({name, "_missing"});
        else begin
            check({name, "_addr"}, wr_log[idx].addr, addr);
            check({name, "_data"}, wr_log[idx].data, data);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_so_data"}, so_data, 0);
        check({tag, "_so_valid"}, so_valid, 0);
        check({tag, "_pixel_wr"}, pixel_wr, 0);
        check({tag, "_dataout"}, pixel_dataout, 0);
        check({tag, "_addr"}, pixel_addr, 8'hFF);
        check({tag, "_finish"}, pixel_finish, 0);
        check({tag, "_ovf"}, ovf, 0);
    endtask

    // Reset asserted between clock edges so the outputs must respond asynchronously.
    task automatic do_reset(input string tag);
        chk_en = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_bits.delete();
        exp_runs.delete();
        exp_wr.delete();
        m_addr   = 255;
        m_writes = 0;
        @(negedge clk);
        chk_en = 1'b1;
    endtask

    task automatic wait_ready(input string what);
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (ready !== 1'b1) fail_now({what, "_ready_timeout"});
    endtask

    task automatic wait_finish(input string what);
        int k;
        k = 0;
        while (pixel_finish !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (pixel_finish !== 1'b1) fail_now({what, "_finish_timeout"});
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] len, input bit fill,
                        input bit msb, input bit low, input bit endf);
        wait_ready("send");
        model_frame(d, len, fill, msb, low, endf);
        pi_data   = d;
        pi_length = len;
        pi_fill   = fill;
        pi_msb    = msb;
        pi_low    = low;
        pi_end    = endf;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic drained(input string tag);
        check({tag, "_bits_left"}, exp_bits.size(), 0);
        check({tag, "_writes_left"}, exp_wr.size(), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, w0, w1;
        reset = 1'b1; load = 1'b0; pi_data = '0; pi_length = '0;
        pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;

        // Literal vectors: four frames fill addresses 0..9, the last one ends the image.
        do_reset("rst0");
        w0 = wr_log.size();
        s0 = ser_log.size();
        send(16'hA5C3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_ready("a5c3");
        check("a5c3_nbits", ser_log.size() - s0, 16);
        check("a5c3_serial", ser_val(s0, 16), 64'hA5C3);
        check_wr("a5c3_w0", w0, 0, 8'hA5);
        check_wr("a5c3_w1", w0 + 1, 1, 8'hC3);

        s0 = ser_log.size();
        send(16'h8001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_ready("8001");
        check("8001_serial", ser_val(s0, 8), 64'h01);
        check_wr("8001_w", w0 + 2, 2, 8'h01);

        s0 = ser_log.size();
        send(16'h1234, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_ready("1234");
        check("1234_serial", ser_val(s0, 32), 64'h12340000);
        check_wr("1234_w0", w0 + 3, 3, 8'h12);
        check_wr("1234_w1", w0 + 4, 4, 8'h34);
        check_wr("1234_w2", w0 + 5, 5, 8'h00);
        check_wr("1234_w3", w0 + 6, 6, 8'h00);

        s0 = ser_log.size();
        send(16'h00FF, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_finish("fill10");
        check("00ff_serial", ser_val(s0, 24), 64'hFF0000);
        check_wr("00ff_w0", w0 + 7, 7, 8'hFF);
        check_wr("00ff_w1", w0 + 8, 8, 8'h00);
        check_wr("00ff_w2", w0 + 9, 9, 8'h00);
        check("fill10_count", wr_log.size() - w0 - 10, 246);
        check_wr("fill10_first", w0 + 10, 10, PAD);
        check_wr("fill10_last", wr_log.size() - 1, 255, PAD);
        if (wr_log.size() > w0 + 10)
            check("fill10_span", wr_log[wr_log.size()-1].cyc - wr_log[w0+10].cyc, 245);
        pi_data = 16'hFFFF;
        load    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("done_finish", pixel_finish, 1);
            check("done_ready", ready, 0);
            check("done_so_valid", so_valid, 0);
        end
        load = 1'b0;
        drained("testA");

        // Load during SHIFT is ignored; mixed modes; reset mid-frame.
        do_reset("rst1");
        w0 = wr_log.size();
        s0 = ser_log.size();
        send(16'hBEEF, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("shift_ready_low", ready, 0);
        pi_data = 16'h0F0F;
        load    = 1'b1;
        repeat (3) @(negedge clk);
        load = 1'b0;
        wait_ready("beef");
        repeat (4) @(negedge clk);
        check("beef_serial", ser_val(s0, 16), 64'hBEEF);
        check("beef_nwrites", wr_log.size() - w0, 2);
        check_wr("beef_w0", w0, 0, 8'hBE);
        check_wr("beef_w1", w0 + 1, 1, 8'hEF);
        send(16'h12AB, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_ready("12ab");
        check_wr("12ab_w", w0 + 2, 2, 8'hAB);
        send(16'h12AB, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        send(16'h12AB, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        send(16'hC001, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_ready("mix");
        drained("testB");
        send(16'h1357, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        do_reset("rst_mid");
        w1 = wr_log.size();
        repeat (4) @(negedge clk);
        send(16'h00C3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_ready("after_rst");
        check_wr("after_rst_w", w1, 0, 8'hC3);
        drained("testB2");

        // 256 writes then one more wraps to 0 and sets ovf; the fill then covers 1..255.
        do_reset("rst2");
        w0 = wr_log.size();
        for (int i = 0; i < 64; i++)
            send(16'(32'h1000 + i * 291), 2'd3, i[1], i[0], 1'b0, 1'b0);
        send(16'h00A7, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_finish("wrap");
        check_wr("wrap_last_before", w0 + 255, 255, wr_log.size() > w0 + 255 ? wr_log[w0+255].data : -1);
        check_wr("wrap_w", w0 + 256, 0, 8'hA7);
        check("wrap_ovf", ovf, 1);
        check("wrap_fill_count", wr_log.size() - w0 - 257, 255);
        drained("testC");

        // Image ends exactly at the last address: no fill writes at all.
        do_reset("rst3");
        w0 = wr_log.size();
        for (int i = 0; i < 64; i++)
            send(16'(i * 1031 + 7), 2'd3, i[2], ~i[0], 1'b0, i == 63);
        wait_finish("nofill");
        repeat (3) @(negedge clk);
        check("nofill_count", wr_log.size() - w0, 256);
        check("nofill_ovf", ovf, 0);
        check("nofill_finish", pixel_finish, 1);
        drained("testD");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
